gp_enc: RTL and testbench

Operand-side encoder for the 17-digit carry-pair prefix network. It accepts operand pairs (A, B) plus an add/subtract select over a valid/ready handshake. For each pair it produces per-digit pair vectors S1 = A & B' (carry-out when carry-in = 0) and S0 = A | B' (carry-out when carry-in = 1), where B' is B or ~B. It also produces the half-sum vector A ^ B' and the carry-in, buffered in a 2-entry queue, so the decoder and sum stage downstream can be back-pressured.

---
 rtl/rdm_pkg.sv | 31 +++
 rtl/gp_fifo2.sv | 72 +++++++
 rtl/gp_enc.sv | 54 +++++
 tb/tb_gp_enc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rdm_pkg.sv
// Shared definitions for the carry-pair prefix datapath: digit width,
// the encoded entry layout and the per-digit pair encode function.
package rdm_pkg;

    localparam int RDM_W     = 17;
    localparam int RDM_TAG_W = 4;

    typedef struct packed {
        logic [RDM_W-1:0]     s1;
        logic [RDM_W-1:0]     s0;
        logic [RDM_W-1:0]     h;
        logic                 cin;
        logic [RDM_TAG_W-1:0] tag;
    } gp_entry_t;

    // Tag is left zero; callers fill it in.
    function automatic gp_entry_t gp_pair(input logic [RDM_W-1:0] a,
                                          input logic [RDM_W-1:0] b,
                                          input logic             sub);
        gp_entry_t        e;
        logic [RDM_W-1:0] bp;
        bp    = sub ? ~b : b;
        e.s1  = a & bp;
        e.s0  = a | bp;
        e.h   = a ^ bp;
        e.cin = sub;
        e.tag = '0;
        return e;
    endfunction

endpackage

// File: rtl/gp_fifo2.sv
// Two-entry valid/ready queue; handshake outputs decode from the registered
// occupancy only, and the data output holds the last popped entry when empty.
//
//   state | meaning
//   EMPTY | no entries; out_data shows last popped entry (0 after reset)
//   ONE   | one entry at rd_ptr
//   TWO   | full, in_ready low
module gp_fifo2 #(
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [P-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] out_data
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

    occ_t         state_q;
    occ_t         state_d;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [P-1:0] mem [2];
    logic [P-1:0] hold;
    logic         push;
    logic         pop;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = (state_q == EMPTY) ? hold : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            hold    <= '0;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                hold   <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

endmodule

// File: rtl/gp_enc.sv
// Operand-side encoder: forms the per-digit (S1, S0), half-sum and carry-in
// for A +/- B and queues them, with a count of completed output transfers.
module gp_enc
    import rdm_pkg::*;
#(
    parameter int W     = RDM_W,
    parameter int TAG_W = RDM_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_s1,
    output logic [W-1:0]     out_s0,
    output logic [W-1:0]     out_h,
    output logic             out_cin,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      xact_cnt
);

    localparam int P = 3 * W + 1 + TAG_W;

    logic [W-1:0] b_eff;
    logic [P-1:0] enc;
    logic [P-1:0] head;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign enc   = {in_a & b_eff, in_a | b_eff, in_a ^ b_eff, in_sub, in_tag};

    gp_fifo2 #(.P(P)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign {out_s1, out_s0, out_h, out_cin, out_tag} = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        xact_cnt <= '0;
        else if (out_valid && out_ready) xact_cnt <= xact_cnt + 16'd1;
    end

endmodule

// File: tb/tb_gp_enc.sv
// Directed bench for gp_enc: encode values, queue ordering, back-pressure,
// reset behaviour and transfer counter wrap.
module tb_gp_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_a;
    logic [16:0] in_b;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_s1;
    logic [16:0] out_s0;
    logic [16:0] out_h;
    logic        out_cin;
    logic [3:0]  out_tag;
    logic [15:0] xact_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    gp_enc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s1    (out_s1),
        .out_s0    (out_s0),
        .out_h     (out_h),
        .out_cin   (out_cin),
        .out_tag   (out_tag),
        .xact_cnt  (xact_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    // advance one edge, then settle inputs/outputs away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [16:0] a, input logic [16:0] b,
                         input logic s, input logic [3:0] t);
        in_valid = v; in_a = a; in_b = b; in_sub = s; in_tag = t;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        drive(1'b0, 17'h0, 17'h0, 1'b0, 4'h0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_s0",        32'(out_s0),    32'd0);
        chk("rst_xact",      32'(xact_cnt),  32'd0);
        step();
        rst = 1'b0;

        // add
        drive(1'b1, 17'h1FFFF, 17'h00001, 1'b0, 4'h3);
        chk("add_pre_valid", 32'(out_valid), 32'd0);
        step();
        drive(1'b0, 17'h0, 17'h0, 1'b0, 4'h0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_s1",    32'(out_s1),    32'h00001);
        chk("add_s0",    32'(out_s0),    32'h1FFFF);
        chk("add_h",     32'(out_h),     32'h1FFFE);
        chk("add_cin",   32'(out_cin),   32'd0);
        chk("add_tag",   32'(out_tag),   32'h3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("add_popped_valid", 32'(out_valid), 32'd0);
        chk("add_hold_s1",      32'(out_s1),    32'h00001);
        chk("add_xact",         32'(xact_cnt),  32'd1);

        // subtract: 5 - 3
        drive(1'b1, 17'h00005, 17'h00003, 1'b1, 4'h5);
        step();
        drive(1'b0, 17'h0, 17'h0, 1'b0, 4'h0);
        chk("sub_s1",  32'(out_s1),  32'h00004);
        chk("sub_s0",  32'(out_s0),  32'h1FFFD);
        chk("sub_h",   32'(out_h),   32'h1FFF9);
        chk("sub_cin", 32'(out_cin), 32'd1);
        chk("sub_tag", 32'(out_tag), 32'h5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("sub_xact", 32'(xact_cnt), 32'd2);

        // back-pressure
        drive(1'b1, 17'h00001, 17'h00002, 1'b0, 4'h1);
        step();
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        drive(1'b1, 17'h00003, 17'h00004, 1'b0, 4'h2);
        step();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head_tag",   32'(out_tag),  32'h1);
        drive(1'b1, 17'h1F0F0, 17'h00FF0, 1'b1, 4'h3);
        step();
        chk("bp_stall_tag", 32'(out_tag),  32'h1);
        chk("bp_stall_s0",  32'(out_s0),   32'h00003);
        chk("bp_stall_h",   32'(out_h),    32'h00003);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        drive(1'b0, 17'h0, 17'h0, 1'b0, 4'h0);
        out_ready = 1'b1;
        step();
        chk("bp_pop2_tag",  32'(out_tag),  32'h2);
        chk("bp_pop2_s0",   32'(out_s0),   32'h00007);
        chk("bp_reready",   32'(in_ready), 32'd1);
        step();
        chk("bp_drained",   32'(out_valid), 32'd0);
        chk("bp_xact",      32'(xact_cnt),  32'd4);
        out_ready = 1'b0;

        // simultaneous push/pop at count 1
        drive(1'b1, 17'h00000, 17'h00000, 1'b0, 4'h0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 17'(i + 1), 17'h0, 1'b0, 4'(i + 1));
            chk("pp_tag",   32'(out_tag),  32'(i));
            chk("pp_ready", 32'(in_ready), 32'd1);
            step();
        end
        out_ready = 1'b0;
        drive(1'b0, 17'h0, 17'h0, 1'b0, 4'h0);
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_last",  32'(out_tag),   32'hA);
        chk("pp_s0",    32'(out_s0),    32'h0000A);
        chk("pp_xact",  32'(xact_cnt),  32'd14);

        // fill to two, then reset mid-operation with a push pending
        drive(1'b1, 17'h00007, 17'h00001, 1'b0, 4'hB);
        step();
        chk("fill_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_ready", 32'(in_ready),  32'd1);
        chk("mrst_xact",  32'(xact_cnt),  32'd0);
        chk("mrst_tag",   32'(out_tag),   32'd0);
        step();
        chk("mrst_discard", 32'(out_valid), 32'd0);
        rst = 1'b0;
        drive(1'b0, 17'h0, 17'h0, 1'b0, 4'h0);
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_s1",    32'(out_s1),    32'd0);

        // counter wrap
        drive(1'b1, 17'h00002, 17'h00001, 1'b0, 4'h6);
        out_ready = 1'b1;
        step();
        repeat (65535) step();
        chk("wrap_ffff", 32'(xact_cnt), 32'h0000FFFF);
        step();
        chk("wrap_zero", 32'(xact_cnt), 32'd0);
        step();
        chk("wrap_one",  32'(xact_cnt), 32'd1);
        chk("wrap_valid", 32'(out_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
